// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counters with registered sync, blanking and
// active-pixel coordinate decodes aligned to the counter value they describe.
module vga_timing_gen #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_ACT   = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_ACT   = 480,
  parameter int V_FRONT = 10
) (
  input  logic        VGA_CLK,
  input  logic        RESET_SYS_N,
  input  logic        EN,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        READ_Request,
  output logic [12:0] H_Cont,
  output logic [12:0] V_Cont,
  output logic [12:0] X_Cont,
  output logic [12:0] Y_Cont,
  output logic        FRAME_START
);

  localparam logic [12:0] H_TOTAL  = 13'(H_SYNC + H_BACK + H_ACT + H_FRONT);
  localparam logic [12:0] V_TOTAL  = 13'(V_SYNC + V_BACK + V_ACT + V_FRONT);
  localparam logic [12:0] H_START  = 13'(H_SYNC + H_BACK);
  localparam logic [12:0] V_START  = 13'(V_SYNC + V_BACK);
  localparam logic [12:0] H_END    = 13'(H_SYNC + H_BACK + H_ACT);
  localparam logic [12:0] V_END    = 13'(V_SYNC + V_BACK + V_ACT);
  localparam logic [12:0] H_SYNC_W = 13'(H_SYNC);
  localparam logic [12:0] V_SYNC_W = 13'(V_SYNC);

  logic [12:0] r_h_cont;
  logic [12:0] r_v_cont;
  logic [12:0] r_x_cont;
  logic [12:0] r_y_cont;
  logic        r_hs;
  logic        r_vs;
  logic        r_blank_n;
  logic        r_origin;

  logic [12:0] w_h_nxt;
  logic [12:0] w_v_nxt;
  logic [12:0] w_x_nxt;
  logic [12:0] w_y_nxt;
  logic        w_h_act;
  logic        w_v_act;

  // Next raster position when enabled; V advances only on the H wrap.
  always_comb begin
    w_h_nxt = r_h_cont + 13'd1;
    w_v_nxt = r_v_cont;
    if (r_h_cont == H_TOTAL - 13'd1) begin
      w_h_nxt = 13'd0;
      if (r_v_cont == V_TOTAL - 13'd1) begin
        w_v_nxt = 13'd0;
      end else begin
        w_v_nxt = r_v_cont + 13'd1;
      end
    end else begin
      w_h_nxt = r_h_cont + 13'd1;
    end
  end

  // Decode the next position so registered outputs line up with the counters.
  always_comb begin
    w_h_act = (w_h_nxt >= H_START) && (w_h_nxt < H_END);
    w_v_act = (w_v_nxt >= V_START) && (w_v_nxt < V_END);
    w_x_nxt = 13'd0;
    w_y_nxt = 13'd0;
    if (w_h_act && w_v_act) begin
      w_x_nxt = w_h_nxt - H_START;
      w_y_nxt = w_v_nxt - V_START;
    end else begin
      w_x_nxt = 13'd0;
      w_y_nxt = 13'd0;
    end
  end

  // Counter and decode registers; reset loads the decode of position (0,0).
  always_ff @(posedge VGA_CLK) begin
    if (!RESET_SYS_N) begin
      r_h_cont  <= 13'd0;
      r_v_cont  <= 13'd0;
      r_x_cont  <= 13'd0;
      r_y_cont  <= 13'd0;
      r_hs      <= 1'b0;
      r_vs      <= 1'b0;
      r_blank_n <= 1'b0;
      r_origin  <= 1'b1;
    end else if (EN) begin
      r_h_cont  <= w_h_nxt;
      r_v_cont  <= w_v_nxt;
      r_x_cont  <= w_x_nxt;
      r_y_cont  <= w_y_nxt;
      r_hs      <= (w_h_nxt >= H_SYNC_W);
      r_vs      <= (w_v_nxt >= V_SYNC_W);
      r_blank_n <= w_h_act && w_v_act;
      r_origin  <= (w_h_nxt == 13'd0) && (w_v_nxt == 13'd0);
    end
  end

  assign H_Cont       = r_h_cont;
  assign V_Cont       = r_v_cont;
  assign X_Cont       = r_x_cont;
  assign Y_Cont       = r_y_cont;
  assign VGA_HS       = r_hs;
  assign VGA_VS       = r_vs;
  assign VGA_BLANK_N  = r_blank_n;
  assign READ_Request = r_blank_n;
  // Gating with EN keeps the pulse off during stalls; gating with reset keeps it off in reset.
  assign FRAME_START  = r_origin & EN & RESET_SYS_N;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the D8M capture path, clocked by the display pixel clock. It produces the horizontal and vertical sync strobes, the raw H/V counters, the active-video read strobe and active-pixel coordinates. The D8M capture/RGB stage uses these to pace its line-buffer reads (READ_Request, VGA_HS, VGA_VS, H_Cont, V_Cont). Defaults give 640x480 @ 60 Hz from a 25 MHz VGA_CLK.

## Interface
Parameters:
- H_SYNC, 96, HS pulse width in clocks
- H_BACK, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, VS pulse width in lines
- V_BACK, 33, vertical back porch
- V_ACT, 480, active lines
- V_FRONT, 10, vertical front porch

Derived values:
- H_TOTAL = sum of the four H parameters (800).
- V_TOTAL = sum of the four V parameters (525).
- H_START = H_SYNC + H_BACK (144).
- V_START = V_SYNC + V_BACK (35).

Ports:
- VGA_CLK, in, 1: sole clock. All logic is synchronous to the rising edge.
- RESET_SYS_N, in, 1: synchronous, active-low reset.
- EN, in, 1: pixel enable. When low, all state holds.
- VGA_HS, out, 1: horizontal sync, active low.
- VGA_VS, out, 1: vertical sync, active low.
- VGA_BLANK_N, out, 1: high inside the active window.
- READ_Request, out, 1: identical to VGA_BLANK_N. Drives downstream line-buffer reads.
- H_Cont, out, 13: horizontal counter, 0..H_TOTAL-1.
- V_Cont, out, 13: vertical counter, 0..V_TOTAL-1.
- X_Cont, out, 13: active pixel column. Equals H_Cont-H_START inside the window, else 0.
- Y_Cont, out, 13: active line. Equals V_Cont-V_START inside the window, else 0.
- FRAME_START, out, 1: one-clock pulse while (H_Cont,V_Cont)=(0,0) and EN=1.

## Operation
Counters:
- H_Cont and V_Cont are the state registers.
- When EN=1, H_Cont increments each clock. At H_Cont=H_TOTAL-1 it wraps to 0 and V_Cont advances.
- V_Cont wraps from V_TOTAL-1 to 0 on the same edge that H_Cont wraps.

Decoding:
- Every other output is a registered decode of the counters' next value. Each output therefore always describes the H_Cont/V_Cont value visible in the same cycle, with zero relative skew.
- VGA_HS = 0 iff H_Cont < H_SYNC.
- VGA_VS = 0 iff V_Cont < V_SYNC.
- H active iff H_START <= H_Cont < H_START+H_ACT.
- V active iff V_START <= V_Cont < V_START+V_ACT.
- VGA_BLANK_N = READ_Request = H active AND V active.
- X_Cont and Y_Cont are 13-bit unsigned subtractions. They are forced to 0 outside the window and never carry negative values.

EN low:
- All registers hold, including FRAME_START's level.
- FRAME_START is defined as the AND of the registered (0,0) decode with EN, so it is never asserted during a stall.

Reset:
- The reset state equals the decode of (0,0): H_Cont=0, V_Cont=0, VGA_HS=0, VGA_VS=0, VGA_BLANK_N=0, READ_Request=0, X_Cont=0, Y_Cont=0.
- FRAME_START is 0 while RESET_SYS_N=0.
- Reset takes priority over EN.

## Timing
- Latency from the counters to every decoded output is 0 cycles: outputs are registered alongside the counters.
- The first edge with RESET_SYS_N=1 and EN=1 gives H_Cont=1, VGA_HS=0. FRAME_START is high during the first post-reset cycle if EN=1.
- Line wrap: the edge after H_Cont=799 shows H_Cont=0, V_Cont+1, VGA_HS=0.
- Frame wrap: the edge after (799,524) shows (0,0), VGA_VS=0 and FRAME_START=1 for one enabled cycle.
- READ_Request rises on the edge into H_Cont=144 and falls on the edge into H_Cont=784, giving exactly 640 high cycles per active line.
- Per frame: 640x480 = 307200 READ_Request cycles, V_ACT active lines, V_SYNC x H_TOTAL VS-low clocks, H_SYNC HS-low clocks per line.
- Reset mid-frame returns to the reset state on the next edge regardless of counter position or EN.

## Test plan
- Reset: hold RESET_SYS_N=0 for 5 clocks from arbitrary state -> H_Cont=0, V_Cont=0, VGA_HS=0, VGA_VS=0, READ_Request=0, X_Cont=0, FRAME_START=0.
- Line timing, EN=1: run one line -> VGA_HS low exactly 96 clocks (H_Cont 0..95); READ_Request high exactly at H_Cont 144..783; X_Cont 0..639 increments with it; H_Cont wraps 799->0 and V_Cont increments.
- Full frame: run 800x525 clocks -> 307200 READ_Request cycles; VGA_VS low for 1600 clocks; Y_Cont 0..479 on V_Cont 35..514; a single FRAME_START pulse at (0,0).
- Stall: drop EN for 7 clocks at H_Cont=300, V_Cont=100 -> every output frozen (X_Cont=156, Y_Cont=65, READ_Request=1); after EN returns, the sequence resumes at H_Cont=301 with no skipped or repeated count.
- Stall at frame origin: EN=0 while at (0,0) -> FRAME_START=0 during the stall, and exactly one FRAME_START cycle once EN=1.
- Reset mid-operation: assert RESET_SYS_N=0 for 1 clock at (500,200) with EN=1 -> the next cycle shows the full reset state; the following enabled cycle shows H_Cont=1, V_Cont=0.
